// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters (ALU, LSU) and the register-file write port.
// The master side is the execute/memory pipeline, and the slave side is the arbiter.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        input  rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        output rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that shares the register-file write port between the ALU (req0)
// and LSU (req1) writeback paths. Grants are combinational, and the write port is
// registered with one cycle of latency. It also keeps commit and contention counters for
// performance debug.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 stall,
    regfile_wb_arbiter_if.slave  bus,
    output logic [CNT_W-1:0]     commit_cnt,
    output logic [CNT_W-1:0]     conflict_cnt
);

    // 1 means req1 won last, so req0 is preferred on the next conflict.
    logic              last_grant;
    logic              grant0;
    logic              grant1;
    logic              xfer0;
    logic              xfer1;
    logic              xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              sel_write;
    logic              conflict;

    // Grant decision: stall and reset block everything, and the contended case alternates.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (reset_n && !stall) begin
            if (bus.req0_valid && !bus.req1_valid) begin
                grant0 = 1'b1;
            end else if (bus.req1_valid && !bus.req0_valid) begin
                grant1 = 1'b1;
            end else if (bus.req0_valid && bus.req1_valid) begin
                if (last_grant) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    // Transfer qualification and selection of the winning payload.
    always_comb begin
        xfer0     = bus.req0_valid && grant0;
        xfer1     = bus.req1_valid && grant1;
        xfer      = xfer0 || xfer1;
        sel_addr  = xfer1 ? bus.req1_addr : bus.req0_addr;
        sel_data  = xfer1 ? bus.req1_data : bus.req0_data;
        // A write to r0 is accepted, but it is never written or counted.
        sel_write = xfer && (sel_addr != '0);
        conflict  = bus.req0_valid && bus.req1_valid && !stall;
    end

    // Round-robin pointer. It moves only when a transfer actually happens.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
        end else if (xfer0) begin
            last_grant <= 1'b0;
        end else if (xfer1) begin
            last_grant <= 1'b1;
        end
    end

    // Registered write port. Address and data hold when there is no transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.rf_we    <= 1'b0;
            bus.rf_waddr <= '0;
            bus.rf_wdata <= '0;
        end else begin
            bus.rf_we <= sel_write;
            if (xfer) begin
                bus.rf_waddr <= sel_addr;
                bus.rf_wdata <= sel_data;
            end
        end
    end

    // Commit counter. It follows rf_we and wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            commit_cnt <= '0;
        end else if (sel_write) begin
            commit_cnt <= commit_cnt + CNT_W'(1);
        end
    end

    // Contention counter. It saturates so that long runs stay readable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            conflict_cnt <= '0;
        end else if (conflict && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

endmodule
